multimode_flipflop_bank: RTL and testbench

//  WIDTH-bit bank of clocked flip-flops with a runtime-selectable mode: SR, JK, D or T.

---
 rtl/multimode_flipflop_bank_pkg.sv | 30 +++
 rtl/multimode_flipflop_bank_if.sv | 30 +++
 rtl/multimode_flipflop_bank_cell.sv | 69 ++++++
 rtl/multimode_flipflop_bank.sv | 63 ++++++
 tb/tb_multimode_flipflop_bank.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/multimode_flipflop_bank_pkg.sv
// Shared encodings for the multimode flip-flop bank: operating modes, the SR S=R=1
// resolution policies and a helper that applies a policy to one channel.
package multimode_flipflop_bank_pkg;

    typedef enum logic [1:0] {
        ModeSr = 2'b00,
        ModeJk = 2'b01,
        ModeD  = 2'b10,
        ModeT  = 2'b11
    } mode_e;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam int unsigned SR_POLICY_HOLD = 0;
    localparam int unsigned SR_POLICY_SET  = 1;
    localparam int unsigned SR_POLICY_CLR  = 2;

    // Unknown policy encodings fall back to hold.
    function automatic logic sr_resolve(input logic q, input int unsigned policy);
        case (policy)
            SR_POLICY_SET: sr_resolve = 1'b1;
            SR_POLICY_CLR: sr_resolve = 1'b0;
            default:       sr_resolve = q;
        endcase
    endfunction

endpackage

// File: rtl/multimode_flipflop_bank_if.sv
// Control/data bundle of the flip-flop bank; the master drives mode and channel
// inputs, the slave (the bank) returns state and error status.
interface multimode_flipflop_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    import multimode_flipflop_bank_pkg::*;

    logic             en;
    mode_e            mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] illegal;
    logic             err_any;
    logic [CNT_W-1:0] err_cnt;
    logic             changed;

    modport master (
        output en, mode, a, b,
        input  q, p, illegal, err_any, err_cnt, changed
    );

    modport slave (
        input  en, mode, a, b,
        output q, p, illegal, err_any, err_cnt, changed
    );

endinterface

// File: rtl/multimode_flipflop_bank_cell.sv
// One flip-flop channel: SR/JK/D/T next-state logic, the state register and the
// registered illegal (S=R=1) pulse. Next-state values are exported for the bank's status logic.
module multimode_flipflop_bank_cell
    import multimode_flipflop_bank_pkg::*;
#(
    parameter logic        RESET_BIT = 1'b0,
    parameter int unsigned SR_POLICY = SR_POLICY_HOLD
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  a,
    input  logic  b,
    output logic  q,
    output logic  q_next,
    output logic  illegal,
    output logic  illegal_next
);

    logic q_d, q_q;
    logic illegal_d, illegal_q;

    always_comb begin
        q_d       = q_q;
        illegal_d = 1'b0;
        if (en) begin
            unique case (mode)
                ModeSr: begin
                    case ({a, b})
                        2'b10:   q_d = 1'b1;
                        2'b01:   q_d = 1'b0;
                        2'b11: begin
                            q_d       = sr_resolve(q_q, SR_POLICY);
                            illegal_d = 1'b1;
                        end
                        default: q_d = q_q;
                    endcase
                end
                ModeJk: begin
                    case ({a, b})
                        2'b10:   q_d = 1'b1;
                        2'b01:   q_d = 1'b0;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                ModeD:  q_d = a;
                ModeT:  q_d = q_q ^ a;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RESET_BIT;
            illegal_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            illegal_q <= illegal_d;
        end
    end

    assign q            = q_q;
    assign q_next       = q_d;
    assign illegal      = illegal_q;
    assign illegal_next = illegal_d;

endmodule

// File: rtl/multimode_flipflop_bank.sv
// WIDTH-channel multimode (SR/JK/D/T) flip-flop bank with sticky error flag, saturating
// illegal-edge counter and a registered change pulse.
module multimode_flipflop_bank
    import multimode_flipflop_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      SR_POLICY = SR_POLICY_HOLD,
    parameter int unsigned      CNT_W     = 8
) (
    input logic                     clk,
    input logic                     rst,
    multimode_flipflop_bank_if.slave bus
);

    logic [WIDTH-1:0] q, q_d, illegal, illegal_d;
    logic             err_any_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        multimode_flipflop_bank_cell #(
            .RESET_BIT (RESET_VAL[i]),
            .SR_POLICY (SR_POLICY)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .en           (bus.en),
            .mode         (bus.mode),
            .a            (bus.a[i]),
            .b            (bus.b[i]),
            .q            (q[i]),
            .q_next       (q_d[i]),
            .illegal      (illegal[i]),
            .illegal_next (illegal_d[i])
        );
    end

    // One count per edge with any illegal channel, regardless of how many.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_any_q <= 1'b0;
            err_cnt_q <= '0;
            changed_q <= 1'b0;
        end else begin
            if (|illegal_d) begin
                err_any_q <= 1'b1;
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
            end
            changed_q <= bus.en && (q_d != q);
        end
    end

    assign bus.q       = q;
    assign bus.p       = ~q;
    assign bus.illegal = illegal;
    assign bus.err_any = err_any_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_multimode_flipflop_bank.sv
// Bench for multimode_flipflop_bank: directed mode scenarios plus randomized traffic
// checked against a vector-arithmetic reference model.
module tb_multimode_flipflop_bank;
    import multimode_flipflop_bank_pkg::*;

    localparam int unsigned W      = 8;
    localparam int unsigned CW     = 8;
    localparam logic [7:0]  RV     = 8'hA5;
    localparam int unsigned POLICY = 0;
    localparam int          CNT_MAX = 255;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    logic [7:0] m_q;
    logic [7:0] m_ill;
    logic       m_chg;
    logic       m_any;
    int         m_cnt;

    multimode_flipflop_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    multimode_flipflop_bank #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .SR_POLICY (POLICY),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pol_bits(input logic [7:0] q, input logic [7:0] ill);
        case (POLICY)
            1:       pol_bits = ill;
            2:       pol_bits = 8'h00;
            default: pol_bits = q & ill;
        endcase
    endfunction

    // Apply one edge's inputs, advance the model, then wait past the edge.
    task automatic step(input logic r, input logic e, input mode_e md,
                        input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] nq, ill, set_m, clr_m;
        rst = r; bus.en = e; bus.mode = md; bus.a = av; bus.b = bv;
        nq  = m_q;
        ill = 8'h00;
        if (e) begin
            case (md)
                ModeSr: begin
                    set_m = av & ~bv;
                    clr_m = ~av & bv;
                    ill   = av & bv;
                    nq    = set_m | (m_q & ~clr_m & ~ill) | pol_bits(m_q, ill);
                end
                ModeJk:  nq = (av & ~m_q) | (~bv & m_q);
                ModeD:   nq = av;
                default: nq = m_q ^ av;
            endcase
        end
        if (r) begin
            m_q = RV; m_ill = 8'h00; m_chg = 1'b0; m_any = 1'b0; m_cnt = 0;
        end else begin
            m_chg = e && (nq != m_q);
            m_ill = ill;
            if (ill != 8'h00) begin
                m_any = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            m_q = nq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, ModeSr, 8'hFF, 8'hFF);
        step(1'b1, 1'b0, ModeSr, 8'h00, 8'h00);
        n_tests++; if (bus.q !== 8'hA5) begin n_fail++; $display("FAIL reset_q got %h want a5", bus.q); end
        n_tests++; if (bus.p !== 8'h5A) begin n_fail++; $display("FAIL reset_p got %h want 5a", bus.p); end
        n_tests++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.err_cnt); end
        n_tests++; if (bus.changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b want 0", bus.changed); end
        n_tests++; if (bus.err_any !== 1'b0 || bus.illegal !== 8'h00) begin
            n_fail++; $display("FAIL reset_err got any=%b ill=%h want 0/00", bus.err_any, bus.illegal);
        end
    endtask

    task automatic test_sr_basic();
        step(1'b0, 1'b1, ModeSr, 8'h0F, 8'hF0);
        n_tests++; if (bus.q !== 8'h0F) begin n_fail++; $display("FAIL sr_set got %h want 0f", bus.q); end
        n_tests++; if (bus.changed !== 1'b1) begin n_fail++; $display("FAIL sr_set_changed got %b want 1", bus.changed); end
        step(1'b0, 1'b1, ModeSr, 8'h00, 8'h00);
        n_tests++; if (bus.q !== 8'h0F) begin n_fail++; $display("FAIL sr_hold got %h want 0f", bus.q); end
        n_tests++; if (bus.changed !== 1'b0) begin n_fail++; $display("FAIL sr_hold_changed got %b want 0", bus.changed); end
    endtask

    task automatic test_sr_illegal();
        step(1'b0, 1'b1, ModeSr, 8'h01, 8'h01);
        n_tests++; if (bus.q !== 8'h0F) begin n_fail++; $display("FAIL ill_q got %h want 0f", bus.q); end
        n_tests++; if (bus.illegal !== 8'h01) begin n_fail++; $display("FAIL ill_pulse got %h want 01", bus.illegal); end
        n_tests++; if (bus.err_any !== 1'b1) begin n_fail++; $display("FAIL ill_any got %b want 1", bus.err_any); end
        n_tests++; if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL ill_cnt got %0d want 1", bus.err_cnt); end
        step(1'b0, 1'b0, ModeSr, 8'h01, 8'h01);
        n_tests++; if (bus.illegal !== 8'h00 || bus.err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL ill_en0 got ill=%h cnt=%0d want 00/1", bus.illegal, bus.err_cnt);
        end
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, ModeSr, 8'h81, 8'h81);
        n_tests++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL ill_sat got %0d want 255", bus.err_cnt); end
        n_tests++; if (bus.illegal !== 8'h81) begin n_fail++; $display("FAIL ill_multi got %h want 81", bus.illegal); end
        step(1'b0, 1'b1, ModeSr, 8'h00, 8'h00);
        n_tests++; if (bus.illegal !== 8'h00 || bus.err_cnt !== 8'd255 || bus.err_any !== 1'b1) begin
            n_fail++; $display("FAIL ill_after got ill=%h cnt=%0d any=%b want 00/255/1",
                               bus.illegal, bus.err_cnt, bus.err_any);
        end
    endtask

    task automatic test_jk_toggle();
        logic [7:0] want [3];
        want[0] = 8'hFF; want[1] = 8'h00; want[2] = 8'hFF;
        step(1'b0, 1'b1, ModeD, 8'h00, 8'h00);
        n_tests++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL jk_pre got %h want 00", bus.q); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, ModeJk, 8'hFF, 8'hFF);
            n_tests++; if (bus.q !== want[i] || bus.changed !== 1'b1 || bus.illegal !== 8'h00) begin
                n_fail++; $display("FAIL jk_toggle%0d got q=%h chg=%b ill=%h want %h/1/00",
                                   i, bus.q, bus.changed, bus.illegal, want[i]);
            end
        end
    endtask

    task automatic test_t_enable_d();
        logic [7:0] want [3];
        logic       wchg [3];
        logic       ens  [3];
        want[0] = 8'hFE; want[1] = 8'hFE; want[2] = 8'hFF;
        wchg[0] = 1'b1;  wchg[1] = 1'b0;  wchg[2] = 1'b1;
        ens[0]  = 1'b1;  ens[1]  = 1'b0;  ens[2]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, ens[i], ModeT, 8'h01, 8'h00);
            n_tests++; if (bus.q !== want[i] || bus.changed !== wchg[i]) begin
                n_fail++; $display("FAIL t_en%0d got q=%h chg=%b want %h/%b",
                                   i, bus.q, bus.changed, want[i], wchg[i]);
            end
        end
        step(1'b0, 1'b1, ModeD, 8'h3C, 8'hFF);
        n_tests++; if (bus.q !== 8'h3C || bus.p !== 8'hC3) begin
            n_fail++; $display("FAIL d_load got q=%h p=%h want 3c/c3", bus.q, bus.p);
        end
    endtask

    task automatic test_reset_during_illegal();
        step(1'b1, 1'b1, ModeSr, 8'hFF, 8'hFF);
        n_tests++; if (bus.err_cnt !== 8'd0 || bus.err_any !== 1'b0) begin
            n_fail++; $display("FAIL rst_ill got cnt=%0d any=%b want 0/0", bus.err_cnt, bus.err_any);
        end
        n_tests++; if (bus.q !== RV || bus.illegal !== 8'h00 || bus.changed !== 1'b0) begin
            n_fail++; $display("FAIL rst_ill_q got q=%h ill=%h chg=%b want a5/00/0",
                               bus.q, bus.illegal, bus.changed);
        end
    endtask

    task automatic test_random();
        step(1'b1, 1'b0, ModeSr, 8'h00, 8'h00);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 mode_e'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            n_tests++;
            if (bus.q !== m_q || bus.p !== ~m_q || bus.illegal !== m_ill || bus.changed !== m_chg ||
                bus.err_any !== m_any || bus.err_cnt !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL random%0d got q=%h p=%h ill=%h chg=%b any=%b cnt=%0d want %h/%h/%h/%b/%b/%0d",
                         i, bus.q, bus.p, bus.illegal, bus.changed, bus.err_any, bus.err_cnt,
                         m_q, ~m_q, m_ill, m_chg, m_any, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.mode = ModeSr; bus.a = '0; bus.b = '0;
        m_q = RV; m_ill = '0; m_chg = 1'b0; m_any = 1'b0; m_cnt = 0;
        #1;
        test_reset();
        test_sr_basic();
        test_sr_illegal();
        test_jk_toggle();
        test_t_enable_d();
        test_reset_during_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
